// File: rtl/mem_stage_pkg.sv
// Shared widths, MEM opcode bit positions and the MEM-stage FSM encoding.
package mem_stage_pkg;

    localparam int unsigned XLEN         = 32;
    localparam int unsigned REG_AW       = 5;
    localparam int unsigned MEM_OP_WIDTH = 3;

    localparam int unsigned MEM_OP_BYTE = 0;
    localparam int unsigned MEM_OP_HALF = 1;
    localparam int unsigned MEM_OP_WORD = 2;

    typedef enum logic [1:0] {
        MS_IDLE,
        MS_WAIT,
        MS_HOLD,
        MS_DRAIN
    } mem_state_t;

endpackage

// File: rtl/mem_stage_load_extend.sv
// Aligns a load word by its byte offset and sign/zero-extends BYTE and HALF loads.
module load_extend
    import mem_stage_pkg::*;
(
    input  logic [MEM_OP_WIDTH-1:0] opcode_i,
    input  logic [1:0]              byte_addr_i,
    input  logic                    unsign_i,
    input  logic [XLEN-1:0]         word_i,
    output logic [XLEN-1:0]         data_o
);

    logic [15:0] s16;

    always_comb begin
        s16    = 16'(word_i >> {byte_addr_i, 3'b000});
        data_o = word_i;
        if (opcode_i[MEM_OP_BYTE]) begin
            data_o = {{(XLEN-8){~unsign_i & s16[7]}}, s16[7:0]};
        end else if (opcode_i[MEM_OP_HALF]) begin
            data_o = {{(XLEN-16){~unsign_i & s16[15]}}, s16[15:0]};
        end else if (opcode_i[MEM_OP_WORD]) begin
            data_o = word_i;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// RV32 MEM stage: waits for load responses, extends load data, registers the WB bundle
// and forwards rd results to ID; responses of killed loads are drained.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter bit SUPPORT_TRAP = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_b,
    output logic                    mem_pipe_ready,
    output logic                    mem_pipe_flush,
    input  logic                    mem_pipe_valid,
    input  logic [XLEN-1:0]         mem_pipe_pc,
    input  logic [XLEN-1:0]         mem_pipe_instruction,
    input  logic [MEM_OP_WIDTH-1:0] mem_pipe_mem_opcode,
    input  logic                    mem_pipe_mem_read,
    input  logic [1:0]              mem_pipe_mem_byte_addr,
    input  logic                    mem_pipe_unsign,
    input  logic                    mem_pipe_rd_write,
    input  logic [REG_AW-1:0]       mem_pipe_rd_addr,
    input  logic [XLEN-1:0]         mem_pipe_alu_result,
    input  logic                    dram_rvalid,
    input  logic [XLEN-1:0]         dram_rdata,
    input  logic                    trap_flush,
    input  logic                    wb_pipe_ready,
    input  logic                    wb_pipe_flush,
    output logic                    wb_pipe_valid,
    output logic [XLEN-1:0]         wb_pipe_pc,
    output logic [XLEN-1:0]         wb_pipe_instruction,
    output logic                    wb_pipe_rd_write,
    output logic [REG_AW-1:0]       wb_pipe_rd_addr,
    output logic [XLEN-1:0]         wb_pipe_rd_wdata,
    output logic                    mem_rd_write,
    output logic [REG_AW-1:0]       mem_rd_addr,
    output logic [XLEN-1:0]         mem_rd_wdata,
    output logic                    mem_load_pending
);

    mem_state_t        state_q;
    logic [XLEN-1:0]   hold_q;
    logic              wb_valid_q;
    logic [XLEN-1:0]   wb_pc_q;
    logic [XLEN-1:0]   wb_instr_q;
    logic              wb_rd_write_q;
    logic [REG_AW-1:0] wb_rd_addr_q;
    logic [XLEN-1:0]   wb_rd_wdata_q;

    logic            mem_valid;
    logic            rsp_live;
    logic            data_avail;
    logic            mem_done;
    logic            capture;
    logic [XLEN-1:0] load_word;
    logic [XLEN-1:0] load_ext;
    logic [XLEN-1:0] rd_wdata;

    assign mem_pipe_flush = (SUPPORT_TRAP && trap_flush) || wb_pipe_flush;
    assign mem_valid      = mem_pipe_valid & ~mem_pipe_flush;
    assign rsp_live       = (state_q == MS_IDLE) || (state_q == MS_WAIT);
    assign data_avail     = ~mem_pipe_mem_read | (state_q == MS_HOLD) | (rsp_live & dram_rvalid);
    assign mem_done       = mem_valid & data_avail;
    assign mem_pipe_ready = (~mem_valid & (state_q != MS_DRAIN)) | (mem_done & wb_pipe_ready);
    assign capture        = mem_valid & mem_pipe_mem_read & rsp_live & dram_rvalid & ~wb_pipe_ready;
    assign load_word      = (state_q == MS_HOLD) ? hold_q : dram_rdata;

    load_extend u_load_extend (
        .opcode_i    (mem_pipe_mem_opcode),
        .byte_addr_i (mem_pipe_mem_byte_addr),
        .unsign_i    (mem_pipe_unsign),
        .word_i      (load_word),
        .data_o      (load_ext)
    );

    assign rd_wdata         = mem_pipe_mem_read ? load_ext : mem_pipe_alu_result;
    assign mem_rd_write     = mem_valid & mem_pipe_rd_write;
    assign mem_rd_addr      = mem_pipe_rd_addr;
    assign mem_rd_wdata     = rd_wdata;
    assign mem_load_pending = mem_valid & mem_pipe_mem_read & ~data_avail;

    // A load killed before its response arrives still owes one rvalid, so it drains.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q <= MS_IDLE;
        end else begin
            case (state_q)
                MS_IDLE: begin
                    if (mem_pipe_valid && mem_pipe_mem_read) begin
                        if (mem_pipe_flush) begin
                            if (!dram_rvalid) state_q <= MS_DRAIN;
                        end else if (!dram_rvalid) begin
                            state_q <= MS_WAIT;
                        end else if (capture) begin
                            state_q <= MS_HOLD;
                        end
                    end
                end
                MS_WAIT: begin
                    if (mem_pipe_flush) begin
                        state_q <= dram_rvalid ? MS_IDLE : MS_DRAIN;
                    end else if (dram_rvalid) begin
                        state_q <= wb_pipe_ready ? MS_IDLE : MS_HOLD;
                    end
                end
                MS_HOLD: begin
                    if (mem_pipe_flush || wb_pipe_ready) state_q <= MS_IDLE;
                end
                MS_DRAIN: begin
                    if (dram_rvalid) state_q <= MS_IDLE;
                end
                default: state_q <= MS_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (capture) hold_q <= dram_rdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            wb_valid_q <= 1'b0;
        end else if (wb_pipe_ready) begin
            wb_valid_q <= mem_done;
        end
    end

    always_ff @(posedge clk) begin
        if (wb_pipe_ready && mem_done) begin
            wb_pc_q       <= mem_pipe_pc;
            wb_instr_q    <= mem_pipe_instruction;
            wb_rd_write_q <= mem_pipe_rd_write;
            wb_rd_addr_q  <= mem_pipe_rd_addr;
            wb_rd_wdata_q <= rd_wdata;
        end
    end

    assign wb_pipe_valid       = wb_valid_q;
    assign wb_pipe_pc          = wb_pc_q;
    assign wb_pipe_instruction = wb_instr_q;
    assign wb_pipe_rd_write    = wb_rd_write_q;
    assign wb_pipe_rd_addr     = wb_rd_addr_q;
    assign wb_pipe_rd_wdata    = wb_rd_wdata_q;

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the 5-stage RV32 pipeline, between EX and WB. It accepts the EX→MEM pipeline bundle and waits for the data-RAM read response of loads already issued by EX. It aligns and sign- or zero-extends the load data and registers the WB pipeline bundle. It also forwards rd results to ID and drains the responses of loads that are killed in flight.

## Interface
- SUPPORT_TRAP, 1, if 0 `trap_flush` is ignored
- clk  in  1  clock
- rst_b  in  1  synchronous active-low reset
- mem_pipe_ready  out  1  MEM can accept a new EX bundle
- mem_pipe_flush  out  1  `trap_flush | wb_pipe_flush`
- mem_pipe_valid  in  1  EX bundle valid
- mem_pipe_pc  in  XLEN  instruction PC
- mem_pipe_instruction  in  XLEN  instruction word
- mem_pipe_mem_opcode  in  MEM_OP_WIDTH  one-hot BYTE/HALF/WORD
- mem_pipe_mem_read  in  1  load whose request EX has issued
- mem_pipe_mem_byte_addr  in  2  address[1:0]
- mem_pipe_unsign  in  1  zero-extend load
- mem_pipe_rd_write  in  1  writes rd
- mem_pipe_rd_addr  in  REG_AW  rd index
- mem_pipe_alu_result  in  XLEN  ALU/link result
- dram_rvalid  in  1  read response valid
- dram_rdata  in  XLEN  read response word
- trap_flush  in  1  trap unit kills MEM and everything younger
- wb_pipe_ready  in  1  WB accepts
- wb_pipe_flush  in  1  WB-originated flush
- wb_pipe_valid  out  1  WB bundle valid
- wb_pipe_pc  out  XLEN  PC
- wb_pipe_instruction  out  XLEN  instruction
- wb_pipe_rd_write  out  1  writes rd
- wb_pipe_rd_addr  out  REG_AW  rd index
- wb_pipe_rd_wdata  out  XLEN  final rd data
- mem_rd_write  out  1  forward: valid rd write in MEM
- mem_rd_addr  out  REG_AW  forward address
- mem_rd_wdata  out  XLEN  forward data
- mem_load_pending  out  1  load in MEM without data; ID must stall dependents

## Operation
- Bus contract: responses return in order, one per accepted request, and at most one request is outstanding. `dram_rvalid` arrives no earlier than the first cycle the load is valid in MEM.
- `mem_valid = mem_pipe_valid & ~mem_pipe_flush`.
- FSM states, with transitions:
  - IDLE: no load waiting.
  - IDLE→WAIT: `mem_valid & mem_pipe_mem_read & ~dram_rvalid`.
  - IDLE, load with rvalid in the same cycle: the load completes directly. If `wb_pipe_ready` is low, rdata is captured and the FSM goes to HOLD.
  - WAIT: load waiting for rvalid.
  - WAIT→IDLE: on rvalid when `wb_pipe_ready` is high.
  - WAIT→HOLD: on rvalid when `wb_pipe_ready` is low. HOLD keeps the captured word in a one-entry buffer.
  - HOLD→IDLE: when `wb_pipe_ready` is high.
  - DRAIN: a killed load still has a response outstanding.
  - Flush in WAIT goes to DRAIN. Flush in HOLD discards the buffer and goes to IDLE.
  - DRAIN→IDLE: on the next rvalid, which is discarded.
- `data_avail = ~mem_pipe_mem_read | (state==HOLD) | ((state==IDLE|state==WAIT) & dram_rvalid)`. The load word comes from the buffer in HOLD, otherwise from `dram_rdata`.
- `mem_done = mem_valid & data_avail`.
- `mem_pipe_ready = ~mem_valid&(state!=DRAIN) | mem_done&wb_pipe_ready`.
- Load extension, with `s = word >> (8*byte_addr)`:
  - BYTE: `s[7:0]`, sign bit 7 unless `mem_pipe_unsign`.
  - HALF: `s[15:0]`, sign bit 15 unless `mem_pipe_unsign`.
  - WORD: unchanged.
- `rd_wdata` is the extended load when `mem_read`, otherwise `mem_pipe_alu_result`.
- Forwarding:
  - `mem_rd_write = mem_valid & mem_pipe_rd_write`
  - `mem_rd_wdata = rd_wdata`
  - `mem_load_pending = mem_valid & mem_pipe_mem_read & ~data_avail`

## Timing
- Reset values: `wb_pipe_valid`=0, state=IDLE, buffer invalid. WB data registers are not reset.
- `wb_pipe_valid` updates only when `wb_pipe_ready` is high, to `mem_done`. The data registers load only on `wb_pipe_ready & mem_done`.
- Latency:
  - Non-load: 1 cycle MEM→WB.
  - Load: 1 cycle after rvalid. The path is combinational from `dram_rdata` to the WB register.
- Simultaneous events:
  - Flush with rvalid in WAIT: the response is consumed and discarded. Next state is IDLE, not DRAIN.
  - Flush with no load: no state change.
- Reset mid-WAIT or mid-DRAIN: the FSM returns to IDLE. The bus is reset together with the core.

## Structure
- `core.svh` gains the `mem_state_t` enum (IDLE, WAIT, HOLD, DRAIN).
- MEM_OP bit indices already live in `core.svh`.
- Sub-module `load_extend`: combinational; inputs opcode, byte_addr, unsign, word; output the extended XLEN value.

## Test plan
- LB, byte_addr=3, unsign=0, rdata=0x80FF_0000, rvalid in the same cycle → `wb_pipe_rd_wdata`=0xFFFF_FF80 next cycle.
- LHU, byte_addr=2, rdata=0xBEEF_1234, rvalid 3 cycles late → `mem_load_pending` high 3 cycles, `mem_pipe_ready` low, then WB=0x0000_BEEF.
- LW, rvalid=0xDEAD_BEEF while `wb_pipe_ready`=0 for 2 cycles → HOLD. WB gets 0xDEAD_BEEF when ready rises and rvalid is not needed again.
- Load in WAIT, `trap_flush` pulse → DRAIN, `mem_pipe_ready`=0. The next rvalid is discarded and `wb_pipe_valid` stays 0.
- ADD result 0x1234 with rd=5 → forward `mem_rd_addr`=5, `mem_rd_wdata`=0x1234. WB gets it 1 cycle later and `mem_load_pending`=0.
- `rst_b` low during WAIT → state IDLE, `wb_pipe_valid`=0 the next cycle.
